// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the instruction/data RAM arbiter.
// Optional feature macro: RAM_ARB_RR_EN (round-robin arbitration, see ram_arb_pick).
package ram_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 12;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned WAIT_W     = 4;

  // Which requester owns the RAM port this cycle.
  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_F,
    SEL_D
  } sel_e;

  // Port that received the most recent grant (round-robin history).
  typedef enum logic {
    WIN_D,
    WIN_F
  } win_e;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational grant selection between the fetch and data ports.
// Default build: data has priority, fetch wins once it has waited MAX_WAIT cycles.
// With RAM_ARB_RR_EN defined: conflicts go to the port that did not win last.
module ram_arb_pick
  import ram_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              f_req,
  input  logic              d_req,
  input  logic [WAIT_W-1:0] wait_cnt,
  input  win_e              last_winner,
  output sel_e              sel
);

`ifdef RAM_ARB_RR_EN

  // Starvation counter and MAX_WAIT play no part in round-robin selection.
  logic unused_rr;
  assign unused_rr = ^{wait_cnt, WAIT_W'(MAX_WAIT)};

  // Round-robin: a lone requester wins; on conflict alternate from last winner.
  always_comb begin
    sel = SEL_NONE;
    if (f_req && d_req) begin
      sel = (last_winner == WIN_F) ? SEL_D : SEL_F;
    end else if (f_req) begin
      sel = SEL_F;
    end else if (d_req) begin
      sel = SEL_D;
    end
  end

`else

  // Winner history is only meaningful in round-robin mode.
  logic unused_prio;
  assign unused_prio = last_winner;

  // Data priority, overridden when fetch has been starved for MAX_WAIT cycles.
  always_comb begin
    sel = SEL_NONE;
    if (f_req && (!d_req || (wait_cnt == WAIT_W'(MAX_WAIT)))) begin
      sel = SEL_F;
    end else if (d_req) begin
      sel = SEL_D;
    end
  end

`endif

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between the fetch (read-only) and data
// (read/write) requesters, returning read data with one cycle of latency and
// holding each port's last read data until its next read.
// Optional feature macro: RAM_ARB_RR_EN (handled inside ram_arb_pick).
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  win_e              last_winner_q, last_winner_d;
  logic              f_pend_q, f_pend_d;
  logic              d_pend_q, d_pend_d;
  logic [DATA_W-1:0] f_hold_q, f_hold_d;
  logic [DATA_W-1:0] d_hold_q, d_hold_d;
  sel_e              sel;

  ram_arb_pick #(
    .MAX_WAIT (MAX_WAIT)
  ) u_pick (
    .f_req       (f_req),
    .d_req       (d_req),
    .wait_cnt    (wait_cnt_q),
    .last_winner (last_winner_q),
    .sel         (sel)
  );

  // Grants and RAM drive; reset suppresses grants and hence writes.
  always_comb begin
    f_gnt    = !rst && (sel == SEL_F);
    d_gnt    = !rst && (sel == SEL_D);
    ram_addr = d_gnt ? d_addr : f_addr;
    ram_data = d_wdata;
    ram_wren = d_gnt && d_we;
  end

  // Read return: rvalid/rdata are forced to reset values while rst is high,
  // so a read granted just before reset never surfaces.
  always_comb begin
    f_rvalid = f_pend_q && !rst;
    d_rvalid = d_pend_q && !rst;
    f_rdata  = '0;
    d_rdata  = '0;
    if (!rst) begin
      f_rdata = f_pend_q ? ram_q : f_hold_q;
      d_rdata = d_pend_q ? ram_q : d_hold_q;
    end
  end

  // Next-state: starvation counter, winner history, pend flags, hold registers.
  always_comb begin
    wait_cnt_d = '0;
    if (f_req && !f_gnt) begin
      wait_cnt_d = (wait_cnt_q == WAIT_W'(MAX_WAIT)) ? wait_cnt_q
                                                     : wait_cnt_q + WAIT_W'(1);
    end

    last_winner_d = last_winner_q;
    if (f_gnt) begin
      last_winner_d = WIN_F;
    end else if (d_gnt) begin
      last_winner_d = WIN_D;
    end

    f_pend_d = f_gnt;
    d_pend_d = d_gnt && !d_we;
    f_hold_d = f_pend_q ? ram_q : f_hold_q;
    d_hold_d = d_pend_q ? ram_q : d_hold_q;
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q    <= '0;
      last_winner_q <= WIN_D;
      f_pend_q      <= 1'b0;
      d_pend_q      <= 1'b0;
      f_hold_q      <= '0;
      d_hold_q      <= '0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      last_winner_q <= last_winner_d;
      f_pend_q      <= f_pend_d;
      d_pend_q      <= d_pend_d;
      f_hold_q      <= f_hold_d;
      d_hold_q      <= d_hold_d;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural 1-cycle RAM.
module tb_ram_arbiter;

  logic        clk;
  logic        rst;
  logic        f_req;
  logic [11:0] f_addr;
  logic        f_gnt;
  logic        f_rvalid;
  logic [15:0] f_rdata;
  logic        d_req;
  logic        d_we;
  logic [11:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [15:0] d_rdata;
  logic [11:0] ram_addr;
  logic [15:0] ram_data;
  logic        ram_wren;
  logic [15:0] ram_q;

  int vectors;
  int miscompares;

  ram_arbiter #(
    .ADDR_W   (12),
    .DATA_W   (16),
    .MAX_WAIT (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .f_req    (f_req),
    .f_addr   (f_addr),
    .f_gnt    (f_gnt),
    .f_rvalid (f_rvalid),
    .f_rdata  (f_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .ram_wren (ram_wren),
    .ram_q    (ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: preset contents at 0 and 5, q not updated on write cycles.
  logic [15:0]   mem [0:4095];
  logic [4095:0] wvalid = '0;

  function automatic logic [15:0] preset(input logic [11:0] a);
    if (a == 12'h000) return 16'h8002;
    if (a == 12'h005) return 16'h5555;
    return 16'h0000;
  endfunction

  always @(posedge clk) begin
    if (ram_wren) begin
      mem[ram_addr]    <= ram_data;
      wvalid[ram_addr] <= 1'b1;
    end else begin
      ram_q <= wvalid[ram_addr] ? mem[ram_addr] : preset(ram_addr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v)
      else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
  endtask

  // Expected {f_gnt, d_gnt} for cycle k of continuous contention.
  function automatic logic [1:0] exp_grant(input int k);
`ifdef RAM_ARB_RR_EN
    return (k % 2 == 0) ? 2'b10 : 2'b01;
`else
    return (k % 5 == 4) ? 2'b10 : 2'b01;
`endif
  endfunction

  logic [1:0] prev;
  logic [1:0] eg;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst     = 1'b1;
    f_req   = 1'b1;
    f_addr  = 12'h000;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 12'h010;
    d_wdata = 16'hffff;

    // Reset with both requests active: everything masked.
    @(negedge clk); #1;
    chk("rst_gnt",    {30'd0, f_gnt, d_gnt}, 32'd0);
    chk("rst_wren",   {31'd0, ram_wren}, 32'd0);
    chk("rst_rvalid", {30'd0, f_rvalid, d_rvalid}, 32'd0);
    chk("rst_rdata",  {f_rdata, d_rdata}, 32'd0);

    @(negedge clk);
    f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    #1;

    // Fetch read of address 0, then hold while RAM q moves to address 5.
    @(negedge clk);
    rst = 1'b0; f_req = 1'b1; f_addr = 12'h000;
    #1;
    chk("t1_gnt",      {30'd0, f_gnt, d_gnt}, 32'd2);
    chk("t1_addr",     {20'd0, ram_addr}, 32'h000);
    chk("t1_rd_post",  {16'd0, f_rdata}, 32'd0);
    @(negedge clk);
    f_req = 1'b0; f_addr = 12'h005;
    #1;
    chk("t1_rvalid",   {31'd0, f_rvalid}, 32'd1);
    chk("t1_rdata",    {16'd0, f_rdata}, 32'h8002);
    chk("t1_gnt_idle", {30'd0, f_gnt, d_gnt}, 32'd0);
    @(negedge clk); #1;
    chk("t1_rvalid_lo", {31'd0, f_rvalid}, 32'd0);
    chk("t1_hold",      {16'd0, f_rdata}, 32'h8002);

    // Data write then read of 0x020.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 12'h020; d_wdata = 16'h1234;
    #1;
    chk("t2_wgnt",  {31'd0, d_gnt}, 32'd1);
    chk("t2_wren",  {31'd0, ram_wren}, 32'd1);
    chk("t2_waddr", {20'd0, ram_addr}, 32'h020);
    chk("t2_wdata", {16'd0, ram_data}, 32'h1234);
    @(negedge clk);
    d_we = 1'b0;
    #1;
    chk("t2_rgnt",    {31'd0, d_gnt}, 32'd1);
    chk("t2_wren_rd", {31'd0, ram_wren}, 32'd0);
    chk("t2_no_wrv",  {31'd0, d_rvalid}, 32'd0);
    @(negedge clk);
    d_req = 1'b0;
    #1;
    chk("t2_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("t2_rdata",  {16'd0, d_rdata}, 32'h1234);
    chk("t2_fhold",  {16'd0, f_rdata}, 32'h8002);
    chk("t2_wren_i", {31'd0, ram_wren}, 32'd0);

    // Continuous contention: fetch reads 0, data reads 0x020.
    prev = 2'b00;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      f_req = 1'b1; f_addr = 12'h000;
      d_req = 1'b1; d_we = 1'b0; d_addr = 12'h020;
      #1;
      eg = exp_grant(k);
      chk($sformatf("t3_gnt_%0d", k),    {30'd0, f_gnt, d_gnt}, {30'd0, eg});
      chk($sformatf("t3_rv_%0d", k),     {30'd0, f_rvalid, d_rvalid}, {30'd0, prev});
      chk($sformatf("t3_addr_%0d", k),   {20'd0, ram_addr}, eg[0] ? 32'h020 : 32'h000);
      if (prev[1]) chk($sformatf("t3_frd_%0d", k), {16'd0, f_rdata}, 32'h8002);
      if (prev[0]) chk($sformatf("t3_drd_%0d", k), {16'd0, d_rdata}, 32'h1234);
      prev = eg;
    end
    @(negedge clk);
    f_req = 1'b0; d_req = 1'b0;
    #1;
    chk("t3_end_gnt", {30'd0, f_gnt, d_gnt}, 32'd0);
    chk("t3_end_rv",  {30'd0, f_rvalid, d_rvalid}, {30'd0, prev});
    chk("t3_end_wr",  {31'd0, ram_wren}, 32'd0);

    // Data read granted, then reset in the following cycle.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 12'h020;
    #1;
    chk("t4_gnt", {31'd0, d_gnt}, 32'd1);
    @(negedge clk);
    d_req = 1'b0; rst = 1'b1;
    #1;
    chk("t4_rst_rv", {30'd0, f_rvalid, d_rvalid}, 32'd0);
    chk("t4_rst_rd", {f_rdata, d_rdata}, 32'd0);
    chk("t4_rst_gw", {29'd0, f_gnt, d_gnt, ram_wren}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t4_post_rv", {31'd0, d_rvalid}, 32'd0);
    chk("t4_post_rd", {f_rdata, d_rdata}, 32'd0);

    // Fetch read of 5 so the last winner is fetch.
    @(negedge clk);
    f_req = 1'b1; f_addr = 12'h005;
    #1;
    chk("t5_fgnt", {30'd0, f_gnt, d_gnt}, 32'd2);
    @(negedge clk);
    f_req = 1'b0;
    #1;
    chk("t5_frd", {16'd0, f_rdata}, 32'h5555);

    // Write against a pending fetch: data first, then fetch.
    @(negedge clk);
    f_req = 1'b1; f_addr = 12'h005;
    d_req = 1'b1; d_we = 1'b1; d_addr = 12'h030; d_wdata = 16'habcd;
    #1;
    chk("t6_gnt",   {30'd0, f_gnt, d_gnt}, 32'd1);
    chk("t6_wren",  {31'd0, ram_wren}, 32'd1);
    chk("t6_addr",  {20'd0, ram_addr}, 32'h030);
    chk("t6_wdata", {16'd0, ram_data}, 32'habcd);
    @(negedge clk);
    d_req = 1'b0;
    #1;
    chk("t6_fgnt",  {30'd0, f_gnt, d_gnt}, 32'd2);
    chk("t6_faddr", {20'd0, ram_addr}, 32'h005);
    chk("t6_fwren", {31'd0, ram_wren}, 32'd0);
    @(negedge clk);
    f_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 12'h030;
    #1;
    chk("t6_dgnt", {30'd0, f_gnt, d_gnt}, 32'd1);
    chk("t6_frv",  {31'd0, f_rvalid}, 32'd1);
    chk("t6_frd",  {16'd0, f_rdata}, 32'h5555);
    @(negedge clk);
    d_req = 1'b0;
    #1;
    chk("t6_drv",   {31'd0, d_rvalid}, 32'd1);
    chk("t6_drd",   {16'd0, d_rdata}, 32'habcd);
    chk("t6_fhold", {16'd0, f_rdata}, 32'h5555);
    @(negedge clk); #1;
    chk("t6_drv_lo", {31'd0, d_rvalid}, 32'd0);
    chk("t6_dhold",  {16'd0, d_rdata}, 32'habcd);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
